// File: rtl/multi_clk_div.sv
// Purpose : CHANNELS independent toggling dividers from one clock, each with a
//           runtime-loadable period, enable, free-run/one-shot mode and global restart.
// Latency : tick/div_clk/done registered, one cycle after the wrap condition; loads
//           apply on the cycle after accept (channel idle) or at the next wrap (running).
// Backpressure: load_ready low while the addressed channel still holds an unapplied period;
//           out-of-range channel numbers are always ready and silently discarded.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   en, oneshot              per-channel run enable and mode (1 = one-shot)
//   restart                  synchronous pulse: zero all counters/outputs, keep periods
//   load_valid/ready/ch/period  period load handshake
//   tick                     one-cycle pulse per wrap
//   div_clk                  toggles on every wrap
//   done                     one-shot completed flag
module multi_clk_div #(
    parameter int               CHANNELS       = 4,
    parameter int               CNT_W          = 32,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(25_000_000),
    parameter int               CH_W           = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic [CHANNELS-1:0] oneshot,
    input  logic                restart,
    input  logic                load_valid,
    input  logic [CH_W-1:0]     load_ch,
    input  logic [CNT_W-1:0]    load_period,
    output logic                load_ready,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] div_clk,
    output logic [CHANNELS-1:0] done
);

    localparam logic [31:0] NUM_CH = 32'(CHANNELS);

    // Per-channel state
    logic [CNT_W-1:0]    cnt    [CHANNELS];
    logic [CNT_W-1:0]    period [CHANNELS];
    logic [CNT_W-1:0]    shadow [CHANNELS];
    logic [CHANNELS-1:0] pend;

    // Combinational decode
    logic [31:0]         load_ch_ext;
    logic                load_in_range;
    logic [CHANNELS-1:0] run;
    logic [CHANNELS-1:0] at_term;
    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] apply;
    logic [CHANNELS-1:0] sel;
    logic [CHANNELS-1:0] accept;

    assign load_ch_ext   = 32'(load_ch);
    assign load_in_range = (load_ch_ext < NUM_CH);

    always_comb begin
        run        = en & ~done;
        at_term    = '0;
        wrap       = '0;
        apply      = '0;
        sel        = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            at_term[i] = (cnt[i] == period[i]);
            wrap[i]    = run[i] && at_term[i];
            // A pending period is only swapped in when the counter is about to be
            // zeroed (idle channel or wrap), so the counter can never sit above a
            // freshly loaded smaller period. restart leaves pend alone entirely.
            apply[i]   = pend[i] && !restart && (!run[i] || at_term[i]);
            sel[i]     = load_in_range && (load_ch_ext == 32'(i));
        end
        // Out-of-range channel: sel is all zero, so ready is high and nothing latches.
        load_ready = ~|(sel & pend);
        accept     = sel & {CHANNELS{load_valid && load_ready}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]    <= '0;
                period[i] <= DEFAULT_PERIOD;
                shadow[i] <= '0;
            end
            pend    <= '0;
            tick    <= '0;
            div_clk <= '0;
            done    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                // accept needs pend=0 and apply needs pend=1, so these never collide;
                // a load accepted on a wrap cycle therefore waits for the next wrap.
                if (accept[i]) begin
                    shadow[i] <= load_period;
                    pend[i]   <= 1'b1;
                end else if (apply[i]) begin
                    period[i] <= shadow[i];
                    pend[i]   <= 1'b0;
                end

                if (restart) begin
                    cnt[i]     <= '0;
                    tick[i]    <= 1'b0;
                    div_clk[i] <= 1'b0;
                    done[i]    <= 1'b0;
                end else if (!en[i]) begin
                    // done can only be set while en is high, so clearing it whenever
                    // en is low is exactly a clear on the falling edge of en.
                    cnt[i]  <= '0;
                    tick[i] <= 1'b0;
                    done[i] <= 1'b0;
                end else if (done[i]) begin
                    // Finished one-shot: parked at zero until en drops or restart.
                    cnt[i]  <= '0;
                    tick[i] <= 1'b0;
                end else if (wrap[i]) begin
                    cnt[i]     <= '0;
                    tick[i]    <= 1'b1;
                    div_clk[i] <= ~div_clk[i];
                    if (oneshot[i]) begin
                        done[i] <= 1'b1;
                    end
                end else begin
                    cnt[i]  <= cnt[i] + CNT_W'(1);
                    tick[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_clk_div.sv
module tb_multi_clk_div;

    localparam int          CH   = 4;
    localparam int          CW   = 32;
    localparam int          CHW  = 3;
    localparam logic [31:0] DEFP = 32'd12;

    logic           clk = 1'b0;
    logic           rst;
    logic [CH-1:0]  en;
    logic [CH-1:0]  oneshot;
    logic           restart;
    logic           load_valid;
    logic [CHW-1:0] load_ch;
    logic [CW-1:0]  load_period;
    logic           load_ready;
    logic [CH-1:0]  tick;
    logic [CH-1:0]  div_clk;
    logic [CH-1:0]  done;

    multi_clk_div #(
        .CHANNELS      (CH),
        .CNT_W         (CW),
        .DEFAULT_PERIOD(DEFP),
        .CH_W          (CHW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .oneshot    (oneshot),
        .restart    (restart),
        .load_valid (load_valid),
        .load_ch    (load_ch),
        .load_period(load_period),
        .load_ready (load_ready),
        .tick       (tick),
        .div_clk    (div_clk),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: each running channel is given an absolute deadline (edge
    // number) at which it must wrap; any stop, wrap or restart disarms it.
    longint      cyc = 0;
    longint      deadline [CH];
    bit          armed    [CH];
    int unsigned m_period [CH];
    int unsigned m_shadow [CH];
    bit          m_pend   [CH];
    logic [CH-1:0] m_tick, m_div, m_done;

    // Observation of DUT ticks for interval checks against fixed numbers
    longint last_tick [CH];
    longint ivl       [CH];
    int     ntick     [CH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            armed[i]    = 1'b0;
            deadline[i] = 0;
            m_period[i] = DEFP;
            m_shadow[i] = 0;
            m_pend[i]   = 1'b0;
            last_tick[i] = -1;
            ivl[i]       = 0;
        end
        m_tick = '0;
        m_div  = '0;
        m_done = '0;
    endtask

    function automatic bit model_ready();
        if (int'(load_ch) >= CH) return 1'b1;
        return !m_pend[load_ch];
    endfunction

    task automatic model_step();
        bit acc;
        bit run;
        bit wrap;
        acc = load_valid && model_ready();
        cyc++;
        for (int i = 0; i < CH; i++) begin
            run  = en[i] && !m_done[i];
            wrap = 1'b0;
            if (restart) begin
                armed[i]  = 1'b0;
                m_tick[i] = 1'b0;
                m_div[i]  = 1'b0;
                m_done[i] = 1'b0;
            end else begin
                if (run) begin
                    if (!armed[i]) begin
                        armed[i]    = 1'b1;
                        deadline[i] = cyc + longint'(m_period[i]);
                    end
                    wrap = (cyc == deadline[i]);
                end else begin
                    armed[i] = 1'b0;
                end
                m_tick[i] = wrap;
                if (wrap) begin
                    m_div[i] = ~m_div[i];
                    armed[i] = 1'b0;
                    if (oneshot[i]) m_done[i] = 1'b1;
                end
                if (!en[i]) m_done[i] = 1'b0;
                if (m_pend[i] && (!run || wrap)) begin
                    m_period[i] = m_shadow[i];
                    m_pend[i]   = 1'b0;
                end
            end
        end
        if (acc && int'(load_ch) < CH) begin
            m_shadow[load_ch] = load_period;
            m_pend[load_ch]   = 1'b1;
        end
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic step(input int n = 1);
        repeat (n) begin
            #1;
            chk("load_ready", 64'(load_ready), 64'(model_ready()));
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("tick", 64'(tick), 64'(m_tick));
            chk("div_clk", 64'(div_clk), 64'(m_div));
            chk("done", 64'(done), 64'(m_done));
            for (int i = 0; i < CH; i++) begin
                if (tick[i]) begin
                    if (last_tick[i] >= 0) ivl[i] = cyc - last_tick[i];
                    last_tick[i] = cyc;
                    ntick[i]++;
                end
            end
        end
    endtask

    task automatic load(input int ch, input int unsigned p);
        load_valid  = 1'b1;
        load_ch     = CHW'(ch);
        load_period = p;
        step(1);
        load_valid  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < CH; i++) ntick[i] = 0;
        rst = 1'b1; en = '0; oneshot = '0; restart = 1'b0;
        load_valid = 1'b0; load_ch = '0; load_period = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_tick", 64'(tick), 64'(0));
        chk("rst_div", 64'(div_clk), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_ready", 64'(load_ready), 64'(1));
        rst = 1'b0;
        step(2);

        // 1: ch0 at period 3
        load(0, 3);
        step(1);
        en = 4'b0001;
        step(20);
        chk("t1_ivl", 64'(ivl[0]), 64'(4));
        chk("t1_idle", 64'(ntick[1] + ntick[2] + ntick[3]), 64'(0));

        // 2: reload ch1 from 3 to 9 while running
        load(1, 3);
        step(1);
        en = 4'b0011;
        step(6);
        load(1, 9);
        load_ch = 3'd1;
        #1;
        chk("t2_rdy_low", 64'(load_ready), 64'(0));
        step(40);
        chk("t2_ivl", 64'(ivl[1]), 64'(10));
        chk("t2_rdy_back", 64'(load_ready), 64'(1));

        // 3: one-shot ch2 at period 5
        load(2, 5);
        step(1);
        oneshot[2] = 1'b1;
        en[2] = 1'b1;
        step(5);
        chk("t3_no_early", 64'(ntick[2]), 64'(0));
        step(1);
        chk("t3_tick6", 64'(tick[2]), 64'(1));
        chk("t3_done", 64'(done[2]), 64'(1));
        step(15);
        chk("t3_single", 64'(ntick[2]), 64'(1));
        en[2] = 1'b0;
        step(1);
        chk("t3_clr", 64'(done[2]), 64'(0));
        en[2] = 1'b1;
        step(6);
        chk("t3_reshot", 64'(ntick[2]), 64'(2));

        // 4: restart with ch0 and ch3 on equal periods
        load(3, 3);
        step(1);
        en = 4'b1011;
        step(5);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("t4_div0", 64'(div_clk), 64'(0));
        step(12);
        chk("t4_sync", 64'(last_tick[3]), 64'(last_tick[0]));

        // 5: period 0 on ch0, applied at its next wrap
        load(0, 0);
        step(6);
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("t5_tick", 64'(tick[0]), 64'(1));
        end

        // random phase, including out-of-range channels and restart pulses
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0) en = CH'($urandom);
            if ($urandom_range(0, 19) == 0) oneshot = CH'($urandom);
            restart     = ($urandom_range(0, 49) == 0);
            load_valid  = ($urandom_range(0, 4) == 0);
            load_ch     = CHW'($urandom_range(0, 7));
            load_period = $urandom_range(0, 12);
            step(1);
        end
        restart = 1'b0;
        load_valid = 1'b0;

        // 6: async reset mid-count with a load outstanding
        oneshot = '0;
        load(1, 2);
        load(2, 7);
        en = 4'b1111;
        step(3);
        load(3, 30);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_tick", 64'(tick), 64'(0));
        chk("t6_div", 64'(div_clk), 64'(0));
        chk("t6_done", 64'(done), 64'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        en = 4'b0001;
        load_ch = 3'd3;
        #1;
        chk("t6_ready", 64'(load_ready), 64'(1));
        step(30);
        chk("t6_defp", 64'(ivl[0]), 64'(DEFP + 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
